// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the seven-segment scan driver.
// Segment codes are active-low {g,f,e,d,c,b,a}.
package seg7_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Entry 15 first so SEG_LUT[n] gives the code for hex digit n.
  localparam logic [15:0][6:0] SEG_LUT = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  // Bit i set when nibble i and every nibble above it are zero.
  // Bit 0 is never set so an all-zero value still shows one "0".
  function automatic logic [15:0] lzb_mask(input logic [63:0] snap);
    logic [15:0] m;
    logic        all_zero;
    m        = '0;
    all_zero = 1'b1;
    for (int i = 15; i >= 1; i--) begin
      all_zero = all_zero && (snap[4*i +: 4] == 4'h0);
      m[i]     = all_zero;
    end
    return m;
  endfunction

endpackage

// File: rtl/seg7_scan_display_clk_div_gen.sv
// Free-running divider: one-cycle terminal-count tick every DIV clocks
// plus a square wave that toggles on each tick.
module clk_div_gen #(
  parameter int DIV = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o,
  output logic sq_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sq_q, sq_d;

  assign tick_o = (cnt_q == CW'(DIV - 1));
  assign sq_o   = sq_q;

  always_comb begin
    cnt_d = tick_o ? '0 : cnt_q + 1'b1;
    sq_d  = sq_q ^ tick_o;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      sq_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sq_q  <= sq_d;
    end
  end

endmodule

// File: rtl/seg7_scan_display.sv
// Time-multiplexed common-anode seven-segment driver with per-frame snapshot,
// leading-zero blanking, blank mask, and a divided slow clock output.
module seg7_scan_display
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 100000,
  parameter int CLK_DIV    = 50000000
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic [4*NUM_DIGITS-1:0] Value,
  input  logic                    Freeze,
  input  logic                    LzbEn,
  input  logic [NUM_DIGITS-1:0]   BlankMask,
  output logic [6:0]              out7,
  output logic [NUM_DIGITS-1:0]   en_out,
  output logic                    ClkOut
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic scan_tick, unused_scan_sq, unused_clk_tick;

  clk_div_gen #(.DIV(SCAN_DIV)) u_scan_div (
    .clk_i  (Clk),
    .rst_i  (Rst),
    .tick_o (scan_tick),
    .sq_o   (unused_scan_sq)
  );

  clk_div_gen #(.DIV(CLK_DIV)) u_core_div (
    .clk_i  (Clk),
    .rst_i  (Rst),
    .tick_o (unused_clk_tick),
    .sq_o   (ClkOut)
  );

  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] snap_q, snap_d;
  logic                    first_q;
  logic [6:0]              out7_q, out7_d;
  logic [NUM_DIGITS-1:0]   en_q, en_d;

  logic        frame_wrap;
  logic [3:0]  cur_nib;
  logic        cur_mask;
  logic [15:0] lzb_all;
  logic        dark;

  assign frame_wrap = scan_tick && (idx_q == IW'(NUM_DIGITS - 1));

  // Snapshot only at frame boundaries (or the first cycle out of reset)
  // so a digit never mixes nibbles from two different source values.
  always_comb begin
    idx_d  = idx_q;
    snap_d = snap_q;
    if (scan_tick) idx_d = frame_wrap ? '0 : idx_q + 1'b1;
    if ((first_q || frame_wrap) && !Freeze) snap_d = Value;
  end

  always_comb begin
    cur_nib  = 4'h0;
    cur_mask = 1'b0;
    en_d     = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        cur_nib  = snap_q[4*i +: 4];
        cur_mask = BlankMask[i];
        en_d[i]  = 1'b0;
      end
    end
    lzb_all = lzb_mask(64'(snap_q));
    dark    = cur_mask || (LzbEn && lzb_all[4'(idx_q)]);
    out7_d  = dark ? SEG_OFF : SEG_LUT[cur_nib];
    // Outputs stay dark while the first snapshot is being captured.
    if (first_q) begin
      en_d   = '1;
      out7_d = SEG_OFF;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      idx_q   <= '0;
      snap_q  <= '0;
      first_q <= 1'b1;
      out7_q  <= SEG_OFF;
      en_q    <= '1;
    end else begin
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      first_q <= 1'b0;
      out7_q  <= out7_d;
      en_q    <= en_d;
    end
  end

  assign out7   = out7_q;
  assign en_out = en_q;

endmodule

// File: doc/seg7_scan_display.md
Name: seg7_scan_display

Overview:
- Parametrised, time-multiplexed seven-segment display driver and slow-clock generator for the FPGA CPU tops (single-cycle and pipelined).
- Takes a packed hex value from the CPU, such as a register or a write-back result, and snapshots it once per display frame so the display never tears.
- Scans NUM_DIGITS common-anode digits, with optional leading-zero blanking and a per-digit blank mask.
- Generates ClkOut, a divided square wave the CPU top uses as its slow core clock for visible stepping.

Parameters:
- NUM_DIGITS, 8, number of digits scanned; range 1..16; sets the width of en_out.
- SCAN_DIV, 100000, Clk cycles each digit stays enabled; minimum 2.
- CLK_DIV, 50000000, Clk cycles per ClkOut half-period; minimum 1 (1 gives Clk/2).

Ports:
- Clk  in  1  system clock; all state updates on its rising edge.
- Rst  in  1  synchronous, active-high reset.
- Value  in  4*NUM_DIGITS  hex nibbles; nibble i, bits [4i+3:4i], drives digit i; digit 0 is rightmost.
- Freeze  in  1  while high, the frame snapshot is not updated and the display holds its current value.
- LzbEn  in  1  enables leading-zero blanking.
- BlankMask  in  NUM_DIGITS  bit i=1 forces digit i dark.
- out7  out  7  segments {g,f,e,d,c,b,a}, active-low, registered.
- en_out  out  NUM_DIGITS  digit anodes, active-low, one-hot-low, registered.
- ClkOut  out  1  divided clock, registered, 50% duty.

Behaviour:
- Reset, when Rst is high at a rising edge:
  - out7=7'h7F; en_out=all ones; ClkOut=0.
  - scan counter=0; digit index=0; ClkOut counter=0; snapshot=0.
  - Reset asserted mid-frame or mid-ClkOut period aborts immediately; there is no partial state.
- Scan counter:
  - Counts 0..SCAN_DIV-1 and wraps to 0.
  - The cycle in which it equals SCAN_DIV-1 is the scan tick.
  - On a scan tick, the digit index increments and wraps from NUM_DIGITS-1 to 0.
- Snapshot:
  - Loaded from Value on the scan tick that wraps the index to 0, and only if Freeze=0.
  - Also loaded on the first cycle after reset deasserts, if Freeze=0.
  - Value changes at any other time have no effect until the next frame boundary.
- Output latency:
  - out7 and en_out are registered from the current index and the snapshot, so they lag an index change by exactly 1 Clk cycle.
  - First valid output: the 2nd rising edge after Rst falls, with en_out=~1 (only bit 0 low).
- en_out: bit idx is low, all other bits are high. It is driven even for blanked digits so scan timing stays uniform.
- Segment decode (active-low):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78.
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (all hex).
- Blanking:
  - A digit is dark (out7=7F) if BlankMask[idx]=1.
  - A digit is also dark if LzbEn=1, idx>0, and every snapshot nibble at positions >= idx is 0.
  - Digit 0 is never LZB-blanked, so a snapshot of 0 shows a single "0".
  - LzbEn and BlankMask are sampled live, not snapshotted.
- ClkOut:
  - A counter runs 0..CLK_DIV-1; on the terminal count ClkOut toggles and the counter wraps.
  - ClkOut period = 2*CLK_DIV Clk cycles.
  - ClkOut is independent of Freeze and of the scan logic.
- NUM_DIGITS=1: the index stays 0, en_out is constantly 0 after reset, and the snapshot reloads every scan tick.

Decomposition:
- Package seg7_pkg holds:
  - the 16-entry active-low segment lookup constant;
  - SEG_OFF=7'h7F;
  - a helper function that computes the leading-zero mask from the snapshot.
- One sub-module, clk_div_gen (parameter DIV):
  - outputs a one-cycle terminal-count tick and a toggling square wave;
  - instantiated twice: once for the scan tick (tick used) and once for ClkOut (square wave used).
- The snapshot, index and output registers live in the top.

Test Plan (NUM_DIGITS=4, SCAN_DIV=4, CLK_DIV=3):
- Reset check: hold Rst for 3 cycles mid-scan -> out7=7F, en_out=F, ClkOut=0 during reset. After release, the 2nd edge gives en_out=E and out7=digit-0 code.
- Scan order: Value=16'h1A3F, LzbEn=0 -> en_out sequence E,D,B,7 with 4 cycles each. out7 sequence 0E,30,08,79, then the pattern repeats from E.
- Leading-zero blanking: Value=16'h0050, LzbEn=1 -> digit0=40, digit1=12, digits 2 and 3=7F. Value=0 -> digit0=40, digits 1..3=7F.
- No tearing, and Freeze: change Value from 16'h1111 to 16'h2222 while idx=2 -> digits 2 and 3 still show 79 in this frame; 24 appears from the next frame. Freeze=1 across a boundary -> the old value persists.
- BlankMask: BlankMask=4'b0101, Value=16'h8888 -> digits 0 and 2 show 7F, digits 1 and 3 show 00, and en_out timing is unchanged.
- ClkOut: after reset, ClkOut toggles every 3 cycles (high 3, low 3). Assert Rst mid-high -> ClkOut=0 next cycle and the period restarts from 0.
